pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Physical-memory-side responder for the line-granular pmem protocol driven by the
//  L1 cache arbiter: accepts one pmem_read/pmem_write request at a time, waits a
//  programmable latency, then returns one pmem_resp pulse with a 128-bit line.
//  Backed by an internal line array; serves as the synthesizable L2/DRAM stand-in
//  under the arbiter, and as the reference responder for arbiter/cache benches.
// PARAMETERS
//  LINE_IDX_BITS  5  line-index width; array holds 2**LINE_IDX_BITS lines
//  LATENCY        4  cycles from request accept edge to pmem_resp cycle; legal 1..15
// PORTS
//  clk            in   1    clock; all state updates on rising edge
//  reset          in   1    synchronous, active-high reset
//  pmem_read      in   1    read request; held by initiator until pmem_resp
//  pmem_write     in   1    write request; held by initiator until pmem_resp
//  pmem_address   in   16   byte address (lc3b_word); [3:0] ignored, index=[4+:LINE_IDX_BITS]
//  pmem_wdata     in   128  write line (lc3b_8word), sampled at accept
//  pmem_resp      out  1    one-cycle completion pulse
//  pmem_rdata     out  128  read line (lc3b_8word); valid in pmem_resp cycle of a read
//  busy           out  1    1 in WAIT and RESP
//  proto_err      out  1    sticky: read and write asserted together in IDLE
//  rd_count       out  16   completed reads, wraps 0xFFFF->0
//  wr_count       out  16   completed writes, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; pmem_resp=0, pmem_rdata=0, busy=0, proto_err=0, counts=0;
//   all array lines cleared to 0. Reset mid-operation abandons request, no array write.
//  FSM IDLE/WAIT/RESP; pmem_resp and busy decoded from registered state only
//   (no input-to-output combinational path).
//  IDLE: exactly one of read/write high -> latch op, index, wdata; load cnt=LATENCY-1;
//   next WAIT (LATENCY=1: next RESP directly). Both high -> set proto_err, stay IDLE,
//   no accept. Neither -> stay IDLE.
//  WAIT: request dropped, op changed, or index changed vs latched -> abort: IDLE,
//   no array write, no count change, proto_err unchanged. Else cnt==0 -> RESP, else cnt--.
//  Entering RESP on read: pmem_rdata <= array[idx]; pmem_rdata otherwise holds last
//   read line (writes never change pmem_rdata).
//  RESP (exactly one cycle): pmem_resp=1; on exit edge: write -> array[idx]<=latched
//   wdata, wr_count++; read -> rd_count++; next IDLE always.
//  Latency: request first sampled in IDLE at edge E0 -> pmem_resp high in cycle after
//   edge E(LATENCY). Back-to-back: new request accepted in IDLE cycle after RESP; min
//   gap between resp pulses = LATENCY+1 cycles.
//  Read-after-write same line: write commits at RESP exit, so next read sees new data.
//  Request bits sampled only in IDLE/WAIT; values during RESP ignored.
// TESTING
//  After reset, LATENCY=4: read 0x0040 held -> pmem_resp exactly once, 4 cycles after
//   accept, pmem_rdata=0, rd_count=1.
//  Write 0x0050 wdata=128'h0123..CDEF then read 0x005A -> read returns 0123..CDEF;
//   read 0x0040 still 0; wr_count=1, rd_count=1.
//  pmem_read&pmem_write both high 1 cycle in IDLE -> no resp, proto_err=1 stays set
//   through later good transactions until reset.
//  Drop pmem_write after 2 WAIT cycles -> no resp, line unchanged, wr_count unchanged;
//   next read accepted immediately.
//  Assert reset during WAIT of write -> outputs/counts 0 next cycle, line stays 0.
//  Preload rd_count=0xFFFF via 65535 reads (or force) -> next read wraps to 0x0000.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Line-granular pmem responder: one request at a time, programmable latency,
// single-cycle pmem_resp pulse, backed by an internal resettable line array.
module pmem_line_responder #(
  parameter int unsigned LINE_IDX_BITS = 5,
  parameter int unsigned LATENCY       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned LINES    = 1 << LINE_IDX_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                   r_state;
  logic                     r_op_wr;
  logic [LINE_IDX_BITS-1:0] r_idx;
  logic [127:0]             r_wdata;
  logic [3:0]               r_cnt;
  logic [127:0]             r_mem [LINES];
  logic [127:0]             r_rdata;
  logic                     r_proto_err;
  logic [15:0]              r_rd_count;
  logic [15:0]              r_wr_count;

  logic [LINE_IDX_BITS-1:0] w_idx;
  logic                     w_one_req;
  logic                     w_both_req;
  logic                     w_abort;
  logic                     w_unused_addr;

  assign w_idx         = pmem_address[4 +: LINE_IDX_BITS];
  assign w_unused_addr = ^{pmem_address[3:0], pmem_address[15:4+LINE_IDX_BITS]};
  assign w_one_req     = pmem_read ^ pmem_write;
  assign w_both_req    = pmem_read & pmem_write;
  // Any change to the held request (drop, op flip, both high, new line) abandons it.
  assign w_abort       = !w_one_req || (pmem_write != r_op_wr) || (w_idx != r_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op_wr     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        r_mem[i[LINE_IDX_BITS-1:0]] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_both_req) begin
            r_proto_err <= 1'b1;
          end else if (w_one_req) begin
            r_op_wr <= pmem_write;
            r_idx   <= w_idx;
            r_wdata <= pmem_wdata;
            r_cnt   <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              if (!pmem_write) r_rdata <= r_mem[w_idx];
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            if (!r_op_wr) r_rdata <= r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Commit happens on the exit edge so a following read sees the new line.
          if (r_op_wr) begin
            r_mem[r_idx] <= r_wdata;
            r_wr_count   <= r_wr_count + 16'd1;
          end else begin
            r_rd_count   <= r_rd_count + 16'd1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pmem_resp  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign pmem_rdata = r_rdata;
  assign proto_err  = r_proto_err;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder (LATENCY=4, 32 lines).
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
  logic         proto_err;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  always #5 clk = ~clk;

  pmem_line_responder #(
    .LINE_IDX_BITS(5),
    .LATENCY(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata),
    .busy(busy),
    .proto_err(proto_err),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  typedef struct {
    logic         is_rd;
    logic [127:0] data;
  } exp_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           resp_seen = 0;
  exp_t         sb[$];
  logic [127:0] model [32];
  logic [127:0] last_rd;
  logic [15:0]  exp_rd;
  logic [15:0]  exp_wr;

  localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && pmem_resp) begin
      resp_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) begin
          chk("rdata", pmem_rdata, e.data);
          last_rd = e.data;
        end else begin
          chk("rdata_hold_on_write", pmem_rdata, last_rd);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    last_rd = '0;
    exp_rd  = '0;
    exp_wr  = '0;
    sb.delete();
  endtask

  task automatic txn(input bit rd, input logic [15:0] addr, input logic [127:0] wd);
    exp_t e;
    int   cyc;
    logic [4:0] idx;
    idx     = addr[8:4];
    e.is_rd = rd;
    e.data  = model[idx];
    sb.push_back(e);
    if (!rd) model[idx] = wd;
    pmem_read    = rd;
    pmem_write   = !rd;
    pmem_address = addr;
    pmem_wdata   = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("busy_in_wait", busy, 1'b1);
    end while (!pmem_resp && cyc < 20);
    chk("latency", cyc, 5);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (rd) exp_rd++;
    else    exp_wr++;
    @(negedge clk);
    chk("rd_count", rd_count, exp_rd);
    chk("wr_count", wr_count, exp_wr);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_resp", pmem_resp, 1'b0);
    chk("rst_rdata", pmem_rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
    chk("rst_rdcnt", rd_count, '0);
    chk("rst_wrcnt", wr_count, '0);
    reset = 1'b0;
    @(negedge clk);

    // basic read, write, read-after-write on same line
    txn(1'b1, 16'h0040, '0);
    txn(1'b0, 16'h0050, W1);
    txn(1'b1, 16'h005A, '0);
    txn(1'b1, 16'h0040, '0);

    // both requests high in IDLE
    pmem_read  = 1'b1;
    pmem_write = 1'b1;
    pmem_address = 16'h0050;
    @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    n = resp_seen;
    repeat (6) @(negedge clk);
    chk("proto_set", proto_err, 1'b1);
    chk("proto_noresp", resp_seen, n);
    chk("proto_rdcnt", rd_count, exp_rd);
    txn(1'b1, 16'h0050, '0);
    chk("proto_sticky", proto_err, 1'b1);

    // drop write after two WAIT cycles
    n = resp_seen;
    pmem_write   = 1'b1;
    pmem_address = 16'h0060;
    pmem_wdata   = 128'hDEAD;
    repeat (3) @(negedge clk);
    pmem_write = 1'b0;
    @(negedge clk);
    txn(1'b1, 16'h0060, '0);
    chk("abort_one_resp", resp_seen, n + 1);

    // index change during WAIT
    n = resp_seen;
    pmem_write   = 1'b1;
    pmem_address = 16'h0070;
    pmem_wdata   = 128'hBEEF;
    repeat (2) @(negedge clk);
    pmem_address = 16'h0080;
    @(negedge clk);
    pmem_write = 1'b0;
    repeat (6) @(negedge clk);
    chk("idxchg_noresp", resp_seen, n);
    txn(1'b1, 16'h0070, '0);
    txn(1'b1, 16'h0080, '0);

    // back-to-back mixed traffic against the model
    for (int k = 0; k < 10; k++) begin
      logic [15:0]  a;
      logic [127:0] d;
      a = 16'($urandom_range(0, 16'h01FF));
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(1'($urandom_range(0, 1)), a, d);
    end

    // reset during WAIT of a write
    pmem_write   = 1'b1;
    pmem_address = 16'h0090;
    pmem_wdata   = 128'hCAFE;
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    pmem_write = 1'b0;
    @(negedge clk);
    chk("midrst_resp", pmem_resp, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rdata", pmem_rdata, '0);
    chk("midrst_proto", proto_err, 1'b0);
    chk("midrst_rdcnt", rd_count, '0);
    chk("midrst_wrcnt", wr_count, '0);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    txn(1'b1, 16'h0090, '0);
    txn(1'b1, 16'h0050, '0);

    // rd_count wrap
    force dut.r_rd_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_rd_count;
    @(negedge clk);
    chk("preload_rdcnt", rd_count, 16'hFFFF);
    exp_rd = 16'hFFFF;
    txn(1'b1, 16'h0040, '0);
    chk("wrap_rdcnt", rd_count, 16'h0000);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
